// File: rtl/mean_filter_mc.sv
// Streaming N x N box-mean filter over CHANNELS packed samples, AXI4-Stream in/out, 3-stage pipeline.
// Define MF_ROUND_EN to round the mean half-up; left undefined the mean is truncated.
module mean_filter_mc #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHANNELS     = 1,
  parameter int WINDOW_SIZE  = 3,
  parameter int FRAME_WIDTH  = 20,
  parameter int FRAME_HEIGHT = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH*CHANNELS-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tuser,
  output logic                           s_axis_tready,
  output logic [DATA_WIDTH*CHANNELS-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  input  logic                           m_axis_tready,
  output logic                           frame_err
);

  localparam int N  = WINDOW_SIZE;
  localparam int NN = N * N;
  localparam int PW = DATA_WIDTH * CHANNELS;
  localparam int SW = DATA_WIDTH + $clog2(NN);
  localparam int CW = $clog2(FRAME_WIDTH);
  localparam int RW = $clog2(FRAME_HEIGHT);
`ifdef MF_ROUND_EN
  localparam int RND = NN / 2;
`else
  localparam int RND = 0;
`endif
  localparam logic [SW:0] RND_W = (SW+1)'(RND);
  localparam logic [SW:0] DIV_W = (SW+1)'(NN);
  localparam logic [SW:0] MAX_W = (SW+1)'((2 ** DATA_WIDTH) - 1);

  if (!(N == 3 || N == 5 || N == 7)) begin : g_bad_window
    $error("mean_filter_mc: WINDOW_SIZE must be 3, 5 or 7");
  end
  if (FRAME_WIDTH < N || FRAME_HEIGHT < N) begin : g_bad_frame
    $error("mean_filter_mc: frame must be at least WINDOW_SIZE in each dimension");
  end

  logic          ce;
  logic          acc;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          line_end;
  logic          frame_err_q, frame_err_d;

  logic [PW-1:0] lb      [N-1][FRAME_WIDTH];
  logic [PW-1:0] col_vec [N];
  logic [PW-1:0] win_q   [N][N];
  logic [PW-1:0] win_d   [N][N];

  logic          s1_valid_q, s1_valid_d, s1_user_q, s1_user_d, s1_last_q, s1_last_d;
  logic          s2_valid_q, s2_valid_d, s2_user_q, s2_user_d, s2_last_q, s2_last_d;
  logic [SW-1:0] tree_sum [CHANNELS];
  logic [SW-1:0] sum_q    [CHANNELS];
  logic [SW-1:0] sum_d    [CHANNELS];

  logic [SW:0]   rounded  [CHANNELS];
  logic [SW:0]   quot     [CHANNELS];
  logic [PW-1:0] mean_pk;
  logic          m_valid_q, m_valid_d, m_user_q, m_user_d, m_last_q, m_last_d;
  logic [PW-1:0] m_data_q, m_data_d;

  assign ce            = m_axis_tready | ~m_valid_q;
  assign s_axis_tready = ce & ~rst;
  assign acc           = s_axis_tvalid & s_axis_tready;

  // A start-of-frame pixel is always treated as (0,0), whatever the counters say.
  assign cur_col  = s_axis_tuser ? '0 : col_q;
  assign cur_row  = s_axis_tuser ? '0 : row_q;
  assign line_end = (cur_col == CW'(FRAME_WIDTH - 1));

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    frame_err_d = acc & (s_axis_tlast != line_end);
    if (acc) begin
      if (line_end) begin
        col_d = '0;
        row_d = (cur_row == RW'(FRAME_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  // Column entering the window: new pixel on top, older lines below it.
  always_comb begin
    col_vec[0] = s_axis_tdata;
    for (int k = 1; k < N; k++) begin
      col_vec[k] = lb[k-1][cur_col];
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int k = 0; k < N - 1; k++) begin
        lb[k][cur_col] <= col_vec[k];
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N - 1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
        win_d[i][N-1] = col_vec[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_user_d  = s1_user_q;
    s1_last_d  = s1_last_q;
    if (ce) begin
      s1_valid_d = acc & (cur_row >= RW'(N - 1)) & (cur_col >= CW'(N - 1));
      s1_user_d  = (cur_row == RW'(N - 1)) & (cur_col == CW'(N - 1));
      s1_last_d  = line_end;
    end
  end

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      tree_sum[ch] = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          tree_sum[ch] = tree_sum[ch] + SW'(win_q[i][j][ch*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_user_d  = s2_user_q;
    s2_last_d  = s2_last_q;
    sum_d      = sum_q;
    if (ce) begin
      s2_valid_d = s1_valid_q;
      s2_user_d  = s1_user_q;
      s2_last_d  = s1_last_q;
      sum_d      = tree_sum;
    end
  end

  // Divide by the window area; the clamp only matters for impossible sums.
  always_comb begin
    mean_pk = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      rounded[ch] = {1'b0, sum_q[ch]} + RND_W;
      quot[ch]    = rounded[ch] / DIV_W;
      mean_pk[ch*DATA_WIDTH +: DATA_WIDTH] =
        (quot[ch] > MAX_W) ? {DATA_WIDTH{1'b1}} : quot[ch][DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;
    m_last_d  = m_last_q;
    if (ce) begin
      m_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        m_data_d = mean_pk;
        m_user_d = s2_user_q;
        m_last_d = s2_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      frame_err_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_user_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_user_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_user_q    <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      frame_err_q <= frame_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_user_q   <= s1_user_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_user_q   <= s2_user_d;
      s2_last_q   <= s2_last_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_user_q    <= m_user_d;
      m_last_q    <= m_last_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign frame_err     = frame_err_q;

endmodule
